// File: rtl/ff_processor_set_pipeline_mult1.sv
// Feed-forward neuron processor set.
// Each cycle: z activations x z weights -> z/fi neurons (fi-wide dot product + bias),
// followed by sigmoid (ROM) or clipped ReLU. Produces both the activation and its derivative.
// Pipeline: product regs -> log2(fi) adder-tree levels -> bias/shift/saturate -> activation.
// Requires fi >= 2, fi a power of two, and fi dividing z.
module ff_processor_set_pipeline_mult1 #(
    parameter int width    = 10,
    parameter int z        = 32,
    parameter int fi       = 16,
    parameter int int_bits = 2,
    parameter int actfn    = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [width*z-1:0]    act_in_package,
    input  logic [width*z-1:0]    wt_package,
    input  logic [width*z/fi-1:0] bias_package,
    output logic [width*z/fi-1:0] act_out_package,
    output logic [width*z/fi-1:0] adot_out_package
);

    localparam int FRAC     = width - int_bits - 1;
    localparam int LEVELS   = $clog2(fi);
    localparam int NN       = z / fi;
    localparam int PW       = 2 * width;
    localparam int SW       = PW + LEVELS;
    localparam int ADOT_CAP = 2**(FRAC-2) - 1;
    localparam int N_TERMS  = 64;

    localparam logic signed [SW:0]      SAT_HI  = (SW+1)'(2**(width-1) - 1);
    localparam logic signed [SW:0]      SAT_LO  = (SW+1)'(-(2**(width-1)));
    localparam logic signed [width-1:0] FX_ZERO = '0;
    localparam logic signed [width-1:0] FX_ONE  = width'(2**FRAC);
    localparam logic signed [width-1:0] FX_MAX  = width'(2**FRAC - 1);
    localparam logic signed [width-1:0] FX_MIN  = width'(1);

    // Sigmoid table entry for ROM index idx (two's complement x). Evaluated at elaboration only.
    // e^|x| is summed as a Taylor series in Q60 fixed point; sigma and sigma' are then exact
    // integer ratios of e^|x| and 1 + e^|x|, so rounding/floor decisions are not fooled by
    // floating-point error.
    function automatic int sig_rom_val(input int idx, input bit want_adot);
        logic [255:0] one;
        logic [255:0] e_q;
        logic [255:0] term;
        logic [255:0] den;
        logic [255:0] num;
        logic [255:0] q;
        int           v;
        int           n;
        v    = (idx >= 2**(width-1)) ? idx - 2**width : idx;
        n    = (v < 0) ? -v : v;
        one  = 256'd1 << 60;
        e_q  = one;
        term = one;
        for (int k = 1; k < N_TERMS; k++) begin
            term = (term * 256'(n)) / (256'(k) << FRAC);
            e_q  = e_q + term;
        end
        den = one + e_q;
        num = (v < 0) ? one : e_q;
        if (want_adot) begin
            // sigma*(1-sigma) = e/(1+e)^2, floored, then capped below 2^(frac-2)
            q = ((e_q * one) << FRAC) / (den * den);
            if (q > 256'(ADOT_CAP)) begin
                q = 256'(ADOT_CAP);
            end
        end else begin
            // round-to-nearest of num/den * 2^frac
            q = ((num << (FRAC + 1)) + den) / (den << 1);
        end
        return int'(q[31:0]);
    endfunction

    if (actfn == 0) begin : g_rom
        logic [width-1:0] rom_a    [2**width];
        logic [width-1:0] rom_adot [2**width];
        for (genvar i = 0; i < 2**width; i++) begin : g_entry
            localparam int A_VAL = sig_rom_val(i, 1'b0);
            localparam int D_VAL = sig_rom_val(i, 1'b1);
            assign rom_a[i]    = width'(A_VAL);
            assign rom_adot[i] = width'(D_VAL);
        end
    end

    for (genvar k = 0; k < z; k++) begin : g_mul
        logic signed [PW-1:0] a_ext;
        logic signed [PW-1:0] w_ext;
        logic signed [PW-1:0] prod;

        assign a_ext = PW'($signed(act_in_package[k*width +: width]));
        assign w_ext = PW'($signed(wt_package[k*width +: width]));

        // stage 1: full-precision product register
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) prod <= '0;
            else        prod <= a_ext * w_ext;
        end
    end

    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int WI = PW + l;
        for (genvar i = 0; i < (z >> (l + 1)); i++) begin : g_add
            logic signed [WI-1:0] lhs;
            logic signed [WI-1:0] rhs;
            logic signed [WI:0]   sum;

            if (l == 0) begin : g_src
                assign lhs = g_mul[2*i].prod;
                assign rhs = g_mul[2*i+1].prod;
            end else begin : g_src
                assign lhs = g_lvl[l-1].g_add[2*i].sum;
                assign rhs = g_lvl[l-1].g_add[2*i+1].sum;
            end

            // one adder-tree level; one extra bit keeps every partial sum exact
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) sum <= '0;
                else        sum <= (WI+1)'(lhs) + (WI+1)'(rhs);
            end
        end
    end

    logic [width*NN-1:0] bias_dly [LEVELS+1];

    // bias rides alongside the products so it meets its own dot product
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s <= LEVELS; s++) bias_dly[s] <= '0;
        end else begin
            bias_dly[0] <= bias_package;
            for (int s = 1; s <= LEVELS; s++) bias_dly[s] <= bias_dly[s-1];
        end
    end

    for (genvar j = 0; j < NN; j++) begin : g_neu
        logic signed [SW-1:0]    tree_sum;
        logic signed [width-1:0] bias_j;
        logic signed [SW:0]      total;
        logic signed [SW:0]      shifted;
        logic [width-1:0]        x_sat;
        logic [width-1:0]        x_q;
        logic [width-1:0]        a_nxt;
        logic [width-1:0]        d_nxt;
        logic [width-1:0]        a_q;
        logic [width-1:0]        d_q;

        assign tree_sum = g_lvl[LEVELS-1].g_add[j].sum;
        assign bias_j   = bias_dly[LEVELS][j*width +: width];
        assign total    = (SW+1)'(tree_sum) + ((SW+1)'(bias_j) <<< FRAC);
        assign shifted  = total >>> FRAC;

        // clamp the rescaled sum into the width-bit fixed-point range
        always_comb begin
            x_sat = shifted[width-1:0];
            if (shifted > SAT_HI)      x_sat = SAT_HI[width-1:0];
            else if (shifted < SAT_LO) x_sat = SAT_LO[width-1:0];
        end

        // pre-activation register
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) x_q <= '0;
            else        x_q <= x_sat;
        end

        if (actfn == 0) begin : g_fn
            assign a_nxt = g_rom.rom_a[x_q];
            assign d_nxt = g_rom.rom_adot[x_q];
        end else begin : g_fn
            // clipped ReLU; derivative floor of one LSB keeps back-prop from stalling
            always_comb begin
                a_nxt = x_q;
                d_nxt = FX_MAX;
                if ($signed(x_q) <= FX_ZERO) begin
                    a_nxt = FX_MIN;
                    d_nxt = FX_MIN;
                end else if ($signed(x_q) >= FX_ONE) begin
                    a_nxt = FX_MAX;
                    d_nxt = FX_MIN;
                end
            end
        end

        // output registers
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                a_q <= '0;
                d_q <= '0;
            end else begin
                a_q <= a_nxt;
                d_q <= d_nxt;
            end
        end

        assign act_out_package[j*width +: width]  = a_q;
        assign adot_out_package[j*width +: width] = d_q;
    end

endmodule

// File: tb/tb_ff_processor_set_pipeline_mult1.sv
// Bench for ff_processor_set_pipeline_mult1: sigmoid and ReLU instances share stimulus;
// directed cases use fixed expected values, random cases use a real-arithmetic model.
module tb_ff_processor_set_pipeline_mult1;

    localparam int W    = 10;
    localparam int Z    = 32;
    localparam int FI   = 16;
    localparam int NN   = Z / FI;
    localparam int L    = 7;
    localparam int OW   = W * NN;
    localparam int HMAX = 4096;

    logic          clk = 1'b0;
    logic          reset;
    logic [W*Z-1:0] act_in;
    logic [W*Z-1:0] wt_in;
    logic [OW-1:0]  bias_in;
    logic [OW-1:0]  sig_act, sig_adot, relu_act, relu_adot;

    ff_processor_set_pipeline_mult1 #(.width(W), .z(Z), .fi(FI), .int_bits(2), .actfn(0)) u_sig (
        .clk(clk), .reset(reset), .act_in_package(act_in), .wt_package(wt_in),
        .bias_package(bias_in), .act_out_package(sig_act), .adot_out_package(sig_adot));

    ff_processor_set_pipeline_mult1 #(.width(W), .z(Z), .fi(FI), .int_bits(2), .actfn(1)) u_relu (
        .clk(clk), .reset(reset), .act_in_package(act_in), .wt_package(wt_in),
        .bias_package(bias_in), .act_out_package(relu_act), .adot_out_package(relu_adot));

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int rel_edge = 0;

    logic [OW-1:0] e_sa [HMAX];
    logic [OW-1:0] e_sd [HMAX];
    logic [OW-1:0] e_ra [HMAX];
    logic [OW-1:0] e_rd [HMAX];

    function automatic int neuron_x(input logic [W*Z-1:0] a, input logic [W*Z-1:0] w,
                                    input logic [OW-1:0] b, input int j);
        longint acc;
        logic signed [W-1:0] ea, ew, eb;
        int x;
        acc = 0;
        for (int k = 0; k < FI; k++) begin
            ea = a[(j*FI+k)*W +: W];
            ew = w[(j*FI+k)*W +: W];
            acc += longint'(ea) * longint'(ew);
        end
        eb = b[j*W +: W];
        acc += longint'(eb) * 128;
        x = $rtoi($floor(real'(acc) / 128.0));
        if (x > 511) x = 511;
        if (x < -512) x = -512;
        return x;
    endfunction

    task automatic model_store(input int idx, input logic [W*Z-1:0] a,
                               input logic [W*Z-1:0] w, input logic [OW-1:0] b);
        int x, sa, sd, ra, rd;
        real s;
        for (int j = 0; j < NN; j++) begin
            x  = neuron_x(a, w, b, j);
            s  = 1.0 / (1.0 + $exp(-real'(x) / 128.0));
            sa = $rtoi($floor(s * 128.0 + 0.5));
            sd = $rtoi($floor(s * (1.0 - s) * 128.0));
            if (sd > 31) sd = 31;
            if (x <= 0) begin
                ra = 1; rd = 1;
            end else if (x >= 128) begin
                ra = 127; rd = 1;
            end else begin
                ra = x; rd = 127;
            end
            e_sa[idx][j*W +: W] = W'(sa);
            e_sd[idx][j*W +: W] = W'(sd);
            e_ra[idx][j*W +: W] = W'(ra);
            e_rd[idx][j*W +: W] = W'(rd);
        end
    endtask

    task automatic chk(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_all();
        int src;
        logic [OW-1:0] xsa, xsd, xra, xrd;
        src = cyc - (L - 1);
        if (reset == 1'b0) begin
            xsa = '0; xsd = '0; xra = '0; xrd = '0;
        end else if (src < rel_edge) begin
            xsa = 20'h10040; xsd = 20'h07C1F; xra = 20'h00401; xrd = 20'h00401;
        end else begin
            xsa = e_sa[src]; xsd = e_sd[src]; xra = e_ra[src]; xrd = e_rd[src];
        end
        chk("sig_act", sig_act, xsa);
        chk("sig_adot", sig_adot, xsd);
        chk("relu_act", relu_act, xra);
        chk("relu_adot", relu_adot, xrd);
    endtask

    task automatic step(input logic [W*Z-1:0] a, input logic [W*Z-1:0] w, input logic [OW-1:0] b,
                        input bit use_c, input logic [OW-1:0] csa, input logic [OW-1:0] csd,
                        input logic [OW-1:0] cra, input logic [OW-1:0] crd);
        @(negedge clk);
        act_in  = a;
        wt_in   = w;
        bias_in = b;
        if (use_c) begin
            e_sa[cyc+1] = csa; e_sd[cyc+1] = csd; e_ra[cyc+1] = cra; e_rd[cyc+1] = crd;
        end else begin
            model_store(cyc + 1, a, w, b);
        end
        @(posedge clk);
        cyc++;
        #1;
        check_all();
    endtask

    function automatic logic [W*Z-1:0] rand_pkg(input bit full);
        logic [W*Z-1:0] v;
        for (int k = 0; k < Z; k++) begin
            if (full) v[k*W +: W] = W'($urandom);
            else      v[k*W +: W] = W'($urandom_range(0, 63) - 32);
        end
        return v;
    endfunction

    function automatic logic [OW-1:0] rand_bias(input bit full);
        logic [OW-1:0] v;
        for (int j = 0; j < NN; j++) begin
            if (full) v[j*W +: W] = W'($urandom);
            else      v[j*W +: W] = W'($urandom_range(0, 255) - 128);
        end
        return v;
    endfunction

    task automatic rand_step(input int r);
        step(rand_pkg(r % 4 == 0), rand_pkg(r % 5 == 0), rand_bias(r % 2 == 0),
             1'b0, '0, '0, '0, '0);
    endtask

    logic [W*Z-1:0] c1_act, c1_wt, zero_v, sat_v;
    logic [OW-1:0]  c1_bias, c2_bias, zero_b;

    initial begin
        c1_act  = 320'h2000000000a0000000003000000000d800000000c000000000e00000000010000000000800000000;
        c1_wt   = 320'h200000000000000000003000000000d800000000e000000000e00000000010000000000800000000;
        c1_bias = 20'h86280;
        c2_bias = 20'h00700;
        zero_v  = '0;
        zero_b  = '0;
        for (int k = 0; k < Z; k++) sat_v[k*W +: W] = 10'h080;

        act_in  = '0;
        wt_in   = '0;
        bias_in = '0;
        reset   = 1'b1;
        #1 reset = 1'b0;
        #1 check_all();
        repeat (2) begin
            @(posedge clk);
            cyc++;
            #1 check_all();
        end
        reset    = 1'b1;
        rel_edge = cyc + 1;

        step(zero_v, zero_v, zero_b, 1'b0, '0, '0, '0, '0);
        // mixed signs, bias only, all-zero, back to back
        step(c1_act, c1_wt, c1_bias, 1'b1, 20'h1784A, 20'h0641F, 20'h1FC28, 20'h0047F);
        step(c1_act, zero_v, c2_bias, 1'b1, 20'h1000F, 20'h07C0D, 20'h00401, 20'h1FC01);
        step(zero_v, zero_v, zero_b, 1'b1, 20'h10040, 20'h07C1F, 20'h00401, 20'h00401);
        // saturation to 0x1FF
        step(sat_v, sat_v, zero_b, 1'b1, 20'h1F87E, 20'h00802, 20'h1FC7F, 20'h00401);
        repeat (L) step(zero_v, zero_v, zero_b, 1'b0, '0, '0, '0, '0);

        for (int r = 0; r < 80; r++) rand_step(r);

        // reset two cycles after a real input, then only fill values until new data arrives
        step(c1_act, c1_wt, c1_bias, 1'b1, 20'h1784A, 20'h0641F, 20'h1FC28, 20'h0047F);
        rand_step(1);
        rand_step(2);
        #2 reset = 1'b0;
        #1 check_all();
        @(posedge clk);
        cyc++;
        #1 check_all();
        reset    = 1'b1;
        rel_edge = cyc + 1;
        for (int r = 0; r < L + 25; r++) rand_step(r + 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
